// File: rtl/dmem_responder_pkg.sv
// Shared encodings and defaults for the data-memory responder.
// The FSM state type and the load/store control encoding live here.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_STORE = 1'b1;

    localparam int DEF_LATENCY = 2;
    localparam int DEF_AW      = 5;
    localparam int CNT_W       = 3;

    function automatic logic isMisaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with synchronous write, registered read port and
// asynchronous clear of every word and of the read register.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wrEn,
    input  logic          rdEn,
    input  logic          rdClr,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (wrEn) begin
                mem[index] <= wdata;
            end
            // rdata only changes on a capture edge, otherwise it holds
            if (rdEn) begin
                rdata <= mem[index];
            end else if (rdClr) begin
                rdata <= '0;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one load/store, waits LATENCY
// cycles, then issues a one-cycle response.
//
// state | meaning
// IDLE  | ready; a valid request is accepted on the next edge
// WAIT  | access in flight; cntQ counts remaining wait cycles down to 0
// RESP  | resp_valid high for one cycle, then back to IDLE
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int AW      = DEF_AW
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic [15:0] acc_count
);

    stateT             stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [31:0]       addrQ, wdataQ;
    logic              writeQ, errQ;
    logic [15:0]       accCount;

    logic              accept, fire;
    logic [31:0]       curAddr, curWdata;
    logic              curWrite, curMis;

    assign accept = req_valid && (stateQ == IDLE);

    // With LATENCY==1 the commit edge is the accept edge, so use live inputs
    assign curAddr  = (stateQ == IDLE) ? req_addr  : addrQ;
    assign curWdata = (stateQ == IDLE) ? req_wdata : wdataQ;
    assign curWrite = (stateQ == IDLE) ? req_write : writeQ;
    assign curMis   = isMisaligned(curAddr);
    assign fire     = (stateD == RESP) && (stateQ != RESP);

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        stateD = RESP;
                    end else begin
                        stateD = WAIT;
                        cntD   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cntQ == '0) begin
                    stateD = RESP;
                end else begin
                    cntD = cntQ - CNT_W'(1);
                end
            end
            RESP: stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ   <= IDLE;
            cntQ     <= '0;
            addrQ    <= '0;
            wdataQ   <= '0;
            writeQ   <= MEM_LOAD;
            errQ     <= 1'b0;
            accCount <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                addrQ  <= req_addr;
                writeQ <= req_write;
                wdataQ <= req_wdata;
            end
            if (fire) begin
                errQ <= curMis;
            end
            if ((stateQ == RESP) && (accCount != 16'hFFFF)) begin
                accCount <= accCount + 16'd1;
            end
        end
    end

    dmem_array #(.AW(AW)) uArray (
        .clock (clock),
        .reset (reset),
        .wrEn  (fire && (curWrite == MEM_STORE) && !curMis),
        .rdEn  (fire && (curWrite == MEM_LOAD) && !curMis),
        .rdClr (fire && ((curWrite == MEM_STORE) || curMis)),
        .index (curAddr[AW+1:2]),
        .wdata (curWdata),
        .rdata (resp_rdata)
    );

    assign req_ready  = (stateQ == IDLE);
    assign resp_valid = (stateQ == RESP);
    assign resp_err   = resp_valid && errQ;
    assign stall      = req_valid && !resp_valid;
    assign acc_count  = accCount;

endmodule
